// File: rtl/ifu_tag_ctrl_if.sv
// Shared IFU cache types and the tag-controller bus, bundling the fetch, replacement-unit,
// memory and data-array-fill signals around ifu_tag_ctrl.
package ifu_pkg;
    localparam int WAYS_NUM = 16;
    localparam int WAY_W    = $clog2(WAYS_NUM);

    typedef struct packed {
        logic             update_tree;
        logic             cache_miss;
        logic [WAY_W-1:0] hit_cl;
    } t_cache_ctrl_plru;
endpackage

interface ifu_tag_ctrl_if #(
    parameter int ADDR_WIDTH = 32
);
    import ifu_pkg::*;

    logic                  fetch_req_valid;
    logic [ADDR_WIDTH-1:0] fetch_req_addr;
    logic                  fetch_req_ready;
    logic                  fetch_rsp_valid;
    logic                  fetch_rsp_hit;
    logic [WAY_W-1:0]      fetch_rsp_way;
    t_cache_ctrl_plru      cache_ctrl_plru;
    logic [WAY_W-1:0]      evicted_cl;
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic                  mem_rsp_valid;
    logic                  fill_we;
    logic [WAY_W-1:0]      fill_way;
    logic                  flush;

    // The tag controller owns this side of every handshake.
    modport master (
        input  fetch_req_valid, fetch_req_addr, evicted_cl, mem_req_ready, mem_rsp_valid, flush,
        output fetch_req_ready, fetch_rsp_valid, fetch_rsp_hit, fetch_rsp_way, cache_ctrl_plru,
               mem_req_valid, mem_req_addr, fill_we, fill_way
    );

    modport slave (
        output fetch_req_valid, fetch_req_addr, evicted_cl, mem_req_ready, mem_rsp_valid, flush,
        input  fetch_req_ready, fetch_rsp_valid, fetch_rsp_hit, fetch_rsp_way, cache_ctrl_plru,
               mem_req_valid, mem_req_addr, fill_we, fill_way
    );
endinterface

// File: rtl/ifu_tag_ctrl.sv
// Fully-associative IFU tag lookup and miss-fill controller.
// Optional macro IFU_TAG_FLUSH_EN enables tag invalidation through bus.flush while idle.
module ifu_tag_ctrl
    import ifu_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int OFFSET_WIDTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    ifu_tag_ctrl_if.master bus
);
    localparam int TAG_W = ADDR_WIDTH - OFFSET_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_REQ,
        MISS_WAIT,
        FILL
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [TAG_W-1:0]       tag_q;
    logic [TAG_W-1:0]       tags [WAYS_NUM];
    logic [WAYS_NUM-1:0]    valid;
    logic                   hit;
    logic [WAY_W-1:0]       hit_way;
    logic                   accept;
    logic                   flush_now;
    logic                   unused_addr_bits;

    assign unused_addr_bits = ^bus.fetch_req_addr[OFFSET_WIDTH-1:0];

`ifdef IFU_TAG_FLUSH_EN
    assign flush_now = (state == IDLE) && bus.flush;
`else
    logic unused_flush;
    assign unused_flush = bus.flush;
    assign flush_now    = 1'b0;
`endif

    // Scan from the top way down so the lowest matching way wins.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int i = WAYS_NUM - 1; i >= 0; i--) begin
            if (valid[i] && (tags[i] == tag_q)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(i);
            end
        end
    end

    always_comb begin
        state_nxt           = state;
        accept              = 1'b0;
        bus.fetch_req_ready = 1'b0;
        bus.fetch_rsp_valid = 1'b0;
        bus.fetch_rsp_hit   = 1'b0;
        bus.fetch_rsp_way   = '0;
        bus.cache_ctrl_plru = '0;
        bus.mem_req_valid   = 1'b0;
        bus.mem_req_addr    = '0;
        bus.fill_we         = 1'b0;
        bus.fill_way        = '0;

        case (state)
            IDLE: begin
                bus.fetch_req_ready = !flush_now;
                accept              = bus.fetch_req_valid && !flush_now;
                if (accept) begin
                    state_nxt = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    bus.fetch_rsp_valid             = 1'b1;
                    bus.fetch_rsp_hit               = 1'b1;
                    bus.fetch_rsp_way               = hit_way;
                    bus.cache_ctrl_plru.update_tree = 1'b1;
                    bus.cache_ctrl_plru.hit_cl      = hit_way;
                    state_nxt                       = IDLE;
                end else begin
                    state_nxt = MISS_REQ;
                end
            end
            MISS_REQ: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_addr  = {tag_q, {OFFSET_WIDTH{1'b0}}};
                if (bus.mem_req_ready) begin
                    state_nxt = MISS_WAIT;
                end
            end
            MISS_WAIT: begin
                if (bus.mem_rsp_valid) begin
                    state_nxt = FILL;
                end
            end
            FILL: begin
                // The victim way is taken from the replacement unit in this very cycle.
                bus.cache_ctrl_plru.update_tree = 1'b1;
                bus.cache_ctrl_plru.cache_miss  = 1'b1;
                bus.fill_we                     = 1'b1;
                bus.fill_way                    = bus.evicted_cl;
                bus.fetch_rsp_valid             = 1'b1;
                bus.fetch_rsp_way               = bus.evicted_cl;
                state_nxt                       = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            valid <= '0;
            tag_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                tag_q <= bus.fetch_req_addr[ADDR_WIDTH-1:OFFSET_WIDTH];
            end
            if (state == FILL) begin
                valid[bus.evicted_cl] <= 1'b1;
            end
            if (flush_now) begin
                valid <= '0;
            end
        end
    end

    // Tag storage needs no reset; the valid bits gate every use of it.
    always_ff @(posedge clk) begin
        if (state == FILL) begin
            tags[bus.evicted_cl] <= tag_q;
        end
    end
endmodule

// File: tb/tb_ifu_tag_ctrl.sv
// Randomised self-checking bench for ifu_tag_ctrl; the bench plays fetch, memory and the
// replacement unit, and predicts results from a simple array-of-lines cache model.
module tb_ifu_tag_ctrl;
    import ifu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ifu_tag_ctrl_if #(.ADDR_WIDTH(32)) bus();

    ifu_tag_ctrl #(.ADDR_WIDTH(32), .OFFSET_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [27:0] m_tag   [WAYS_NUM];
    bit          m_valid [WAYS_NUM];

    int          o_lat, o_stalls, o_mem_reqs, o_fills, o_tree, o_miss, o_hitcl_bad, o_rsp_count;
    logic        o_hit;
    logic [3:0]  o_way, o_fill_way, o_hit_cl;
    logic [31:0] o_mem_addr;
    bit          o_mem_seen, o_addr_unstable;

    function automatic int model_lookup(input logic [31:0] addr);
        for (int i = 0; i < WAYS_NUM; i++) begin
            if (m_valid[i] && m_tag[i] == addr[31:4]) return i;
        end
        return -1;
    endfunction

    task automatic model_fill(input logic [31:0] addr, input logic [3:0] victim);
        m_tag[victim]   = addr[31:4];
        m_valid[victim] = 1'b1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < WAYS_NUM; i++) m_valid[i] = 1'b0;
    endtask

    task automatic sample_cycle();
        if (bus.cache_ctrl_plru.update_tree) begin
            o_tree++;
            if (!bus.cache_ctrl_plru.cache_miss) o_hit_cl = bus.cache_ctrl_plru.hit_cl;
        end
        if (bus.cache_ctrl_plru.cache_miss) o_miss++;
        if (!(bus.cache_ctrl_plru.update_tree && !bus.cache_ctrl_plru.cache_miss) &&
            bus.cache_ctrl_plru.hit_cl != 4'd0) o_hitcl_bad++;
        if (bus.fill_we) begin
            o_fills++;
            o_fill_way = bus.fill_way;
        end
        if (bus.mem_req_valid) begin
            if (o_mem_seen && bus.mem_req_addr != o_mem_addr) o_addr_unstable = 1'b1;
            o_mem_addr = bus.mem_req_addr;
            o_mem_seen = 1'b1;
            if (bus.mem_req_ready) o_mem_reqs++;
        end
        if (bus.fetch_rsp_valid) begin
            o_rsp_count++;
            o_hit = bus.fetch_rsp_hit;
            o_way = bus.fetch_rsp_way;
        end
    endtask

    // req_low: MISS_REQ cycles with mem_req_ready low; rsp_delay: MISS_WAIT cycles before mem_rsp_valid.
    task automatic run_request(input logic [31:0] addr, input int req_low, input int rsp_delay,
                               input logic [3:0] victim, input bit noise, input bit with_flush);
        int reqcnt;
        int waitcnt;
        bit req_acc;
        bit accepted;
        bit acc_now;
        o_lat = -1; o_stalls = 0; o_mem_reqs = 0; o_fills = 0; o_tree = 0; o_miss = 0;
        o_hitcl_bad = 0; o_rsp_count = 0; o_hit = 1'bx; o_way = 'x; o_fill_way = 'x;
        o_hit_cl = 'x; o_mem_addr = '0; o_mem_seen = 1'b0; o_addr_unstable = 1'b0;
        accepted = 1'b0;
        for (int g = 0; g < 20 && !accepted; g++) begin
            @(negedge clk);
            bus.fetch_req_valid = 1'b1;
            bus.fetch_req_addr  = addr;
            bus.flush           = with_flush && (g == 0);
            bus.evicted_cl      = victim;
            bus.mem_req_ready   = 1'b0;
            bus.mem_rsp_valid   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            sample_cycle();
            if (bus.fetch_req_ready) accepted = 1'b1;
            else o_stalls++;
        end
        if (!accepted) return;
        reqcnt = 0; waitcnt = 0; req_acc = 1'b0;
        for (int c = 1; c <= 200 && o_lat < 0; c++) begin
            @(negedge clk);
            bus.fetch_req_valid = 1'b0;
            bus.flush           = 1'b0;
            bus.fetch_req_addr  = $urandom;
            bus.evicted_cl      = victim;
            bus.mem_req_ready   = (reqcnt >= req_low);
            bus.mem_rsp_valid   = req_acc ? (waitcnt == rsp_delay)
                                          : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
            #1;
            sample_cycle();
            acc_now = bus.mem_req_valid && bus.mem_req_ready;
            if (bus.mem_req_valid) reqcnt++;
            if (req_acc) waitcnt++;
            if (acc_now) req_acc = 1'b1;
            if (bus.fetch_rsp_valid) o_lat = c;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.fetch_req_valid = 1'b0; bus.fetch_req_addr = '0; bus.evicted_cl = '0;
        bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.flush = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (bus.fetch_req_ready !== 1'b1) begin
            n_fail++; $display("[TB] FAIL reset_ready: got %b expected 1", bus.fetch_req_ready);
        end
        n_checks++;
        if ({bus.fetch_rsp_valid, bus.fetch_rsp_hit, bus.fetch_rsp_way, bus.cache_ctrl_plru,
             bus.mem_req_valid, bus.mem_req_addr, bus.fill_we, bus.fill_way} !== '0) begin
            n_fail++; $display("[TB] FAIL reset_outputs: some output nonzero, mem_req_valid=%b fill_we=%b rsp_valid=%b",
                               bus.mem_req_valid, bus.fill_we, bus.fetch_rsp_valid);
        end
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_cold_miss();
        run_request(32'h0000_1000, 0, 0, 4'd0, 1'b0, 1'b0);
        n_checks++;
        if (o_mem_addr !== 32'h0000_1000) begin n_fail++; $display("[TB] FAIL cold_mem_addr: got %h expected 00001000", o_mem_addr); end
        n_checks++;
        if (o_hit !== 1'b0 || o_rsp_count != 1) begin n_fail++; $display("[TB] FAIL cold_rsp: hit=%b rsps=%0d expected hit=0 rsps=1", o_hit, o_rsp_count); end
        n_checks++;
        if (o_fills != 1 || o_fill_way !== 4'd0 || o_way !== 4'd0) begin
            n_fail++; $display("[TB] FAIL cold_fill: fills=%0d fill_way=%0d rsp_way=%0d expected 1/0/0", o_fills, o_fill_way, o_way);
        end
        n_checks++;
        if (o_tree != 1 || o_miss != 1) begin n_fail++; $display("[TB] FAIL cold_plru: tree=%0d miss=%0d expected 1/1", o_tree, o_miss); end
        n_checks++;
        if (o_lat != 4) begin n_fail++; $display("[TB] FAIL cold_latency: got %0d expected 4", o_lat); end
        model_fill(32'h0000_1000, 4'd0);
    endtask

    task automatic test_rehit();
        int exp_way;
        exp_way = model_lookup(32'h0000_100C);
        run_request(32'h0000_100C, 0, 0, 4'd7, 1'b0, 1'b0);
        n_checks++;
        if (o_hit !== 1'b1 || o_way !== 4'(exp_way) || exp_way < 0) begin
            n_fail++; $display("[TB] FAIL rehit_way: hit=%b way=%0d expected hit=1 way=%0d", o_hit, o_way, exp_way);
        end
        n_checks++;
        if (o_lat != 1 || o_mem_reqs != 0 || o_mem_seen) begin
            n_fail++; $display("[TB] FAIL rehit_timing: latency=%0d memreqs=%0d expected 1/0", o_lat, o_mem_reqs);
        end
        n_checks++;
        if (o_tree != 1 || o_miss != 0 || o_hit_cl !== 4'(exp_way) || o_hitcl_bad != 0) begin
            n_fail++; $display("[TB] FAIL rehit_plru: tree=%0d miss=%0d hit_cl=%0d expected 1/0/%0d", o_tree, o_miss, o_hit_cl, exp_way);
        end
    endtask

    task automatic test_fill_all();
        int exp_way;
        logic [3:0] v;
        logic [31:0] a;
        for (int i = 0; i < WAYS_NUM; i++) begin
            a = 32'h0000_1000 + 32'(i) * 32'h10;
            exp_way = model_lookup(a);
            run_request(a, 0, 0, 4'(i), 1'b0, 1'b0);
            n_checks++;
            if (o_hit !== (exp_way >= 0) || o_way !== (exp_way >= 0 ? 4'(exp_way) : 4'(i))) begin
                n_fail++; $display("[TB] FAIL fill_all_%0d: hit=%b way=%0d expected hit=%0d way=%0d", i, o_hit, o_way, exp_way >= 0, exp_way >= 0 ? exp_way : i);
            end
            if (exp_way < 0) model_fill(a, 4'(i));
        end
        v = 4'($urandom_range(0, WAYS_NUM - 1));
        run_request(32'h0000_2000, 0, 0, v, 1'b0, 1'b0);
        n_checks++;
        if (o_hit !== 1'b0 || o_way !== v || o_fill_way !== v) begin
            n_fail++; $display("[TB] FAIL evict_victim: hit=%b way=%0d fill_way=%0d expected 0/%0d/%0d", o_hit, o_way, o_fill_way, v, v);
        end
        model_fill(32'h0000_2000, v);
        a = 32'h0000_1000 + 32'(v) * 32'h10;
        run_request(a, 0, 0, v + 4'd1, 1'b0, 1'b0);
        n_checks++;
        if (o_hit !== 1'b0 || model_lookup(a) != -1) begin
            n_fail++; $display("[TB] FAIL evicted_line_misses: hit=%b expected 0 for %h", o_hit, a);
        end
        model_fill(a, v + 4'd1);
    endtask

    task automatic test_backpressure();
        run_request(32'h0000_5000, 5, 1, 4'd3, 1'b0, 1'b0);
        n_checks++;
        if (o_addr_unstable || o_mem_addr !== 32'h0000_5000) begin
            n_fail++; $display("[TB] FAIL bp_addr: unstable=%0d addr=%h expected stable 00005000", o_addr_unstable, o_mem_addr);
        end
        n_checks++;
        if (o_fills != 1 || o_mem_reqs != 1) begin n_fail++; $display("[TB] FAIL bp_fills: fills=%0d memreqs=%0d expected 1/1", o_fills, o_mem_reqs); end
        n_checks++;
        if (o_lat != 10) begin n_fail++; $display("[TB] FAIL bp_latency: got %0d expected 10", o_lat); end
        model_fill(32'h0000_5000, 4'd3);
    endtask

    task automatic test_back_to_back();
        run_request(32'h0000_5004, 0, 0, 4'd9, 1'b0, 1'b0);
        run_request(32'h0000_5008, 0, 0, 4'd9, 1'b0, 1'b0);
        n_checks++;
        if (o_stalls != 0 || o_hit !== 1'b1 || o_way !== 4'd3 || o_lat != 1) begin
            n_fail++; $display("[TB] FAIL back_to_back: stalls=%0d hit=%b way=%0d lat=%0d expected 0/1/3/1", o_stalls, o_hit, o_way, o_lat);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [3:0]  v;
        int exp_way, rl, rd, exp_lat;
        bit exp_hit;
        for (int n = 0; n < 40; n++) begin
            a  = 32'h0000_4000 + 32'($urandom_range(0, 23)) * 32'h10 + 32'($urandom_range(0, 15));
            v  = 4'($urandom_range(0, WAYS_NUM - 1));
            rl = $urandom_range(0, 3);
            rd = $urandom_range(0, 3);
            exp_way = model_lookup(a);
            exp_hit = (exp_way >= 0);
            exp_lat = exp_hit ? 1 : 4 + rl + rd;
            run_request(a, rl, rd, v, 1'b1, 1'b0);
            n_checks++;
            if (o_hit !== exp_hit || o_way !== (exp_hit ? 4'(exp_way) : v) || o_lat != exp_lat) begin
                n_fail++; $display("[TB] FAIL random_%0d addr=%h: hit=%b way=%0d lat=%0d expected %0d/%0d/%0d",
                                   n, a, o_hit, o_way, o_lat, exp_hit, exp_hit ? exp_way : v, exp_lat);
            end
            n_checks++;
            if (o_tree != 1 || o_miss != (exp_hit ? 0 : 1) || o_fills != (exp_hit ? 0 : 1) ||
                o_rsp_count != 1 || o_hitcl_bad != 0 ||
                (!exp_hit && o_mem_addr !== {a[31:4], 4'h0})) begin
                n_fail++; $display("[TB] FAIL random_side_%0d: tree=%0d miss=%0d fills=%0d rsps=%0d hitcl_bad=%0d memaddr=%h",
                                   n, o_tree, o_miss, o_fills, o_rsp_count, o_hitcl_bad, o_mem_addr);
            end
            if (!exp_hit) model_fill(a, v);
        end
    endtask

    task automatic test_reset_mid_miss();
        int bad;
        bad = 0;
        @(negedge clk);
        bus.fetch_req_valid = 1'b1; bus.fetch_req_addr = 32'h0000_6000;
        bus.mem_req_ready = 1'b1; bus.mem_rsp_valid = 1'b0;
        @(negedge clk);
        bus.fetch_req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        #1;
        n_checks++;
        if (bus.mem_req_valid !== 1'b0 || bus.fetch_req_ready !== 1'b1) begin
            n_fail++; $display("[TB] FAIL rst_mid_state: mem_req_valid=%b ready=%b expected 0/1", bus.mem_req_valid, bus.fetch_req_ready);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            if (bus.fill_we || bus.fetch_rsp_valid || bus.mem_req_valid) bad++;
        end
        bus.mem_rsp_valid = 1'b0;
        n_checks++;
        if (bad != 0) begin n_fail++; $display("[TB] FAIL rst_mid_late_rsp: %0d cycles with activity expected 0", bad); end
        model_clear();
        run_request(32'h0000_5000, 0, 0, 4'd1, 1'b0, 1'b0);
        n_checks++;
        if (o_hit !== 1'b0 || model_lookup(32'h0000_5000) != -1) begin
            n_fail++; $display("[TB] FAIL rst_mid_invalid: hit=%b expected 0", o_hit);
        end
        model_fill(32'h0000_5000, 4'd1);
    endtask

`ifdef IFU_TAG_FLUSH_EN
    task automatic test_flush();
        run_request(32'h0000_7000, 0, 0, 4'd2, 1'b0, 1'b0);
        model_fill(32'h0000_7000, 4'd2);
        run_request(32'h0000_7000, 0, 0, 4'd5, 1'b0, 1'b1);
        model_clear();
        n_checks++;
        if (o_stalls != 1 || o_hit !== (model_lookup(32'h0000_7000) >= 0)) begin
            n_fail++; $display("[TB] FAIL flush: stalls=%0d hit=%b expected 1/0", o_stalls, o_hit);
        end
        model_fill(32'h0000_7000, 4'd5);
    endtask
`else
    task automatic test_flush();
        run_request(32'h0000_7000, 0, 0, 4'd2, 1'b0, 1'b0);
        model_fill(32'h0000_7000, 4'd2);
        run_request(32'h0000_7000, 0, 0, 4'd5, 1'b0, 1'b1);
        n_checks++;
        if (o_stalls != 0 || o_hit !== (model_lookup(32'h0000_7000) >= 0) || o_way !== 4'd2) begin
            n_fail++; $display("[TB] FAIL flush_ignored: stalls=%0d hit=%b way=%0d expected 0/1/2", o_stalls, o_hit, o_way);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_cold_miss();
        test_rehit();
        test_fill_all();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid_miss();
        test_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
